// File: rtl/wb_pipe_multi_pkg.sv
// Shared constants, stage-operation encoding and stall decode for the
// multi-lane MEM->WB pipeline register.
package wb_pipe_multi_pkg;

    localparam int WB_MAX_DEPTH = 4;
    localparam int REG_ADDR_W   = 5;

    localparam logic STOP          = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // What every stage does on the coming posedge
    typedef enum logic [1:0] {
        OP_ADVANCE,
        OP_BUBBLE,
        OP_HOLD,
        OP_CLEAR
    } stage_op_e;

    // Priority: reset > flush > own stall (bubble or hold) > advance
    function automatic stage_op_e decode_op(input logic rst, input logic flush,
                                            input logic stall_self, input logic stall_next);
        if (rst == RST_ENABLE || flush) return OP_CLEAR;
        if (stall_self != STOP)         return OP_ADVANCE;
        if (stall_next != STOP)         return OP_BUBBLE;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/wb_pipe_multi_fwd_mux.sv
// Priority forwarding search over all in-flight stages and lanes.
// Youngest match wins: stage 0 before later stages, higher lane first.
// Address 0 never hits; no hit returns zero data.
module wb_fwd_mux
    import wb_pipe_multi_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic [DEPTH-1:0][LANES-1:0]                 wreg,
    input  logic [DEPTH-1:0][LANES-1:0][REG_ADDR_W-1:0] wd,
    input  logic [DEPTH-1:0][LANES-1:0][DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0]                       raddr,
    output logic                                        hit,
    output logic [DATA_W-1:0]                           data
);

    // Scan oldest to youngest so the last (youngest) match overrides
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (wreg[s][l] == WRITE_ENABLE && wd[s][l] == raddr && raddr != NOP_REG_ADDR) begin
                    hit  = 1'b1;
                    data = wdata[s][l];
                end
            end
        end
    end

endmodule

// File: rtl/wb_pipe_multi.sv
// MEM->WB pipeline register: LANES writeback lanes, DEPTH stages (1..WB_MAX_DEPTH),
// shared HI/LO slot, stall/flush aware.
// Optional feature macro WB_FWD_EN: in-flight forwarding lookup via wb_fwd_mux;
// without it fwd_hit/fwd_data are tied to 0 and fwd_raddr is ignored.
module wb_pipe_multi
    import wb_pipe_multi_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          mem_wreg,
    input  logic [5*LANES-1:0]        mem_wd,
    input  logic [DATA_W*LANES-1:0]   mem_wdata,
    input  logic                      mem_whilo,
    input  logic [DATA_W-1:0]         mem_hi,
    input  logic [DATA_W-1:0]         mem_lo,
    output logic [LANES-1:0]          wb_wreg,
    output logic [5*LANES-1:0]        wb_wd,
    output logic [DATA_W*LANES-1:0]   wb_wdata,
    output logic                      wb_whilo,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_busy,
    input  logic [REG_ADDR_W-1:0]     fwd_raddr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data
);

    // Packed views of every stage, index 0 = youngest
    logic [DEPTH-1:0][LANES-1:0]                 all_wreg;
    logic [DEPTH-1:0][LANES-1:0][REG_ADDR_W-1:0] all_wd;
    logic [DEPTH-1:0][LANES-1:0][DATA_W-1:0]     all_wdata;
    logic [DEPTH-1:0]                            all_whilo;
    logic [DEPTH-1:0][DATA_W-1:0]                all_hi;
    logic [DEPTH-1:0][DATA_W-1:0]                all_lo;

    stage_op_e op;

    // One decode shared by all stages; only stage 0 treats a bubble differently
    always_comb op = decode_op(rst, flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [LANES-1:0]                 src_wreg,  r_wreg;
        logic [LANES-1:0][REG_ADDR_W-1:0] src_wd,    r_wd;
        logic [LANES-1:0][DATA_W-1:0]     src_wdata, r_wdata;
        logic                             src_whilo, r_whilo;
        logic [DATA_W-1:0]                src_hi,    r_hi;
        logic [DATA_W-1:0]                src_lo,    r_lo;

        if (k == 0) begin : g_src_mem
            assign src_wreg  = mem_wreg;
            assign src_wd    = mem_wd;
            assign src_wdata = mem_wdata;
            assign src_whilo = mem_whilo;
            assign src_hi    = mem_hi;
            assign src_lo    = mem_lo;
        end else begin : g_src_prev
            assign src_wreg  = all_wreg[k-1];
            assign src_wd    = all_wd[k-1];
            assign src_wdata = all_wdata[k-1];
            assign src_whilo = all_whilo[k-1];
            assign src_hi    = all_hi[k-1];
            assign src_lo    = all_lo[k-1];
        end

        // Stage register: clear, hold, load bubble (stage 0 only) or load upstream
        always_ff @(posedge clk) begin
            if (op == OP_CLEAR || (op == OP_BUBBLE && k == 0)) begin
                r_wreg  <= {LANES{WRITE_DISABLE}};
                r_wd    <= '0;
                r_wdata <= '0;
                r_whilo <= WRITE_DISABLE;
                r_hi    <= '0;
                r_lo    <= '0;
            end else if (op != OP_HOLD) begin
                r_wreg  <= src_wreg;
                r_wd    <= src_wd;
                r_wdata <= src_wdata;
                r_whilo <= src_whilo;
                r_hi    <= src_hi;
                r_lo    <= src_lo;
            end
        end

        assign all_wreg[k]  = r_wreg;
        assign all_wd[k]    = r_wd;
        assign all_wdata[k] = r_wdata;
        assign all_whilo[k] = r_whilo;
        assign all_hi[k]    = r_hi;
        assign all_lo[k]    = r_lo;
    end

    assign wb_wreg  = all_wreg[DEPTH-1];
    assign wb_wd    = all_wd[DEPTH-1];
    assign wb_wdata = all_wdata[DEPTH-1];
    assign wb_whilo = all_whilo[DEPTH-1];
    assign wb_hi    = all_hi[DEPTH-1];
    assign wb_lo    = all_lo[DEPTH-1];
    assign wb_busy  = (|all_wreg) | (|all_whilo);

    // Only two stall bits matter here; the rest belong to other stages
    logic unused_stall;
    assign unused_stall = ^stall;

`ifdef WB_FWD_EN
    wb_fwd_mux #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fwd (
        .wreg   (all_wreg),
        .wd     (all_wd),
        .wdata  (all_wdata),
        .raddr  (fwd_raddr),
        .hit    (fwd_hit),
        .data   (fwd_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_raddr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_multi.sv
// Bench for wb_pipe_multi (DEPTH=2, LANES=2): reference model of the stage
// contents plus per-cycle output compare and directed literal checks.
module tb_wb_pipe_multi;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int D     = 2;
    localparam int SW    = 6;

    logic                clk = 1'b0;
    logic                rst, flush;
    logic [SW-1:0]       stall;
    logic [LANES-1:0]    mem_wreg;
    logic [5*LANES-1:0]  mem_wd;
    logic [DW*LANES-1:0] mem_wdata;
    logic                mem_whilo;
    logic [DW-1:0]       mem_hi, mem_lo;
    logic [LANES-1:0]    wb_wreg;
    logic [5*LANES-1:0]  wb_wd;
    logic [DW*LANES-1:0] wb_wdata;
    logic                wb_whilo;
    logic [DW-1:0]       wb_hi, wb_lo;
    logic                wb_busy;
    logic [4:0]          fwd_raddr;
    logic                fwd_hit;
    logic [DW-1:0]       fwd_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    wb_pipe_multi #(.LANES(LANES), .DATA_W(DW), .DEPTH(D), .STALL_W(SW), .STAGE_IDX(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_busy(wb_busy),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    // Model: what each in-flight slot holds (index 0 = youngest)
    typedef struct packed {
        logic [1:0]       wreg;
        logic [1:0][4:0]  wd;
        logic [1:0][31:0] wdata;
        logic             whilo;
        logic [31:0]      hi;
        logic [31:0]      lo;
    } ent_t;

    ent_t m [D];

    always @(posedge clk) begin
        ent_t in_e;
        in_e.wreg  = mem_wreg;
        in_e.wd    = mem_wd;
        in_e.wdata = mem_wdata;
        in_e.whilo = mem_whilo;
        in_e.hi    = mem_hi;
        in_e.lo    = mem_lo;
        if (rst || flush) begin
            for (int k = 0; k < D; k++) m[k] = '0;
        end else if (!(stall[4] && stall[5])) begin
            for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
            m[0] = stall[4] ? '0 : in_e;
        end
    end

    function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a == 5'd0) return;
        for (int s = 0; s < D; s++)
            for (int l = LANES - 1; l >= 0; l--)
                if (m[s].wreg[l] && m[s].wd[l] == a) begin
                    h = 1'b1;
                    d = m[s].wdata[l];
                    return;
                end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            logic        eh, busy;
            logic [31:0] ed;
            busy = 1'b0;
            for (int k = 0; k < D; k++) busy |= (|m[k].wreg) | m[k].whilo;
            chk("m_wreg",  wb_wreg,  m[D-1].wreg);
            chk("m_wd",    wb_wd,    m[D-1].wd);
            chk("m_wdata", wb_wdata, m[D-1].wdata);
            chk("m_whilo", wb_whilo, m[D-1].whilo);
            chk("m_hi",    wb_hi,    m[D-1].hi);
            chk("m_lo",    wb_lo,    m[D-1].lo);
            chk("m_busy",  wb_busy,  busy);
`ifdef WB_FWD_EN
            model_fwd(fwd_raddr, eh, ed);
`else
            eh = 1'b0;
            ed = '0;
`endif
            chk("m_fwd_hit",  fwd_hit,  eh);
            chk("m_fwd_data", fwd_data, ed);
        end
    end

    task automatic drive(input logic [1:0] wreg, input logic [4:0] wd0, input logic [31:0] d0,
                         input logic [4:0] wd1, input logic [31:0] d1,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        mem_wreg  = wreg;
        mem_wd    = {wd1, wd0};
        mem_wdata = {d1, d0};
        mem_whilo = whilo;
        mem_hi    = hi;
        mem_lo    = lo;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        xh;
        logic [31:0] xd;
        rst = 1'b1; flush = 1'b0; stall = '0; fwd_raddr = 5'd3;
        drive(2'b11, 5'd3, 32'h11, 5'd7, 32'h22, 1'b1, 32'hA, 32'hB);
        @(posedge clk);
        started = 1'b1;
        #1;
        cyc();
        chk("rst_busy", wb_busy, 0);
        chk("rst_wreg", wb_wreg, 0);
        chk("rst_hi",   wb_hi,   0);

        // Pass-through with 2-cycle latency
        rst = 1'b0;
        cyc();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("lat1_wreg", wb_wreg, 0);
        cyc();
        chk("pass_wd",    wb_wd,    10'h0E3);
        chk("pass_wdata", wb_wdata, 64'h00000022_00000011);
        chk("pass_hi",    wb_hi,    32'hA);
        chk("pass_lo",    wb_lo,    32'hB);

        // Bubble: older result drains, stage 0 gets a bubble
        drive(2'b01, 5'd5, 32'h55, 0, 0, 0, 0, 0);
        cyc();
        drive(2'b01, 5'd6, 32'h66, 0, 0, 0, 0, 0);
        stall = 6'b011111;
        cyc();
        chk("bub_wd5",  wb_wd,   10'h005);
        chk("bub_wreg", wb_wreg, 2'b01);
        stall = '0;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("bub_zero_wreg",  wb_wreg,  0);
        chk("bub_zero_wdata", wb_wdata, 0);

        // Hold for 3 cycles, then resume without loss or duplication
        drive(2'b11, 5'd1, 32'h101, 5'd2, 32'h102, 1'b1, 32'hD1, 32'hD2);
        cyc();
        drive(2'b11, 5'd8, 32'h108, 5'd10, 32'h10A, 1'b0, 0, 0);
        cyc();
        drive(2'b10, 5'd0, 32'h0, 5'd12, 32'h10C, 1'b1, 32'hF1, 32'hF2);
        stall = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_wd", wb_wd, 10'h041);
            chk("hold_hi", wb_hi, 32'hD1);
        end
        stall = '0;
        cyc();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_e_wd", wb_wd, 10'h148);
        chk("resume_e_whilo", wb_whilo, 0);
        cyc();
        chk("resume_f_wd", wb_wd, 10'h180);
        chk("resume_f_hi", wb_hi, 32'hF1);

        // Two lanes with the same destination both pass through
        drive(2'b11, 5'd4, 32'h44, 5'd4, 32'h45, 1'b0, 0, 0);
        cyc();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("same_wd_wdata", wb_wdata, 64'h00000045_00000044);
        chk("same_wd_wreg",  wb_wreg,  2'b11);

        // Reset while holding
        drive(2'b01, 5'd13, 32'h13, 0, 0, 1'b1, 32'h1, 32'h2);
        cyc();
        stall = 6'b111111;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_hold_busy", wb_busy, 0);
        rst = 1'b0;
        stall = '0;

        // Flush beats the bubble stall with both stages valid
        drive(2'b01, 5'd14, 32'h14, 0, 0, 0, 0, 0);
        cyc();
        drive(2'b10, 0, 0, 5'd15, 32'h15, 1'b1, 32'h3, 32'h4);
        cyc();
        chk("pre_flush_busy", wb_busy, 1);
        flush = 1'b1;
        stall = 6'b011111;
        cyc();
        chk("flush_busy", wb_busy, 0);
        chk("flush_wreg", wb_wreg, 0);
        flush = 1'b0;
        stall = '0;

        // Forwarding: youngest match (stage 0 lane 0) wins over stage 1 lane 1
        drive(2'b10, 0, 0, 5'd9, 32'h2, 0, 0, 0);
        cyc();
        drive(2'b01, 5'd9, 32'h1, 0, 0, 0, 0, 0);
        cyc();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0);
        stall = 6'b111111;
        fwd_raddr = 5'd9;
        #1;
`ifdef WB_FWD_EN
        xh = 1'b1; xd = 32'h1;
`else
        xh = 1'b0; xd = 32'h0;
`endif
        chk("fwd9_hit",  fwd_hit,  xh);
        chk("fwd9_data", fwd_data, xd);
        fwd_raddr = 5'd0;
        #1;
        chk("fwd0_hit",  fwd_hit,  0);
        chk("fwd0_data", fwd_data, 0);
        cyc();
        fwd_raddr = 5'd9;
        stall = '0;
        cyc();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
